// File: rtl/data_demux.sv
// Routing demultiplexer: one valid/ready input stream steered by DATAI[SEL_BIT]
// into two independent show-ahead FIFO channels, each with a delivered-word counter.
`timescale 1ns/1ps

module data_demux_ch #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    input  logic             ready,
    output logic [7:0]       cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             pop;

    assign full  = (count == FULL_LEVEL);
    assign valid = (count != '0);
    assign dout  = mem[rd_ptr];
    assign pop   = valid & ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            cnt    <= '0;
            // NOTE: storage is reset too, so DATAOx reads 0 while the channel is empty after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates let push and pop both see this cycle's pointers.
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                cnt    <= cnt + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

module data_demux #(
    parameter int WIDTH   = 32,
    parameter int SEL_BIT = 2,
    parameter int DEPTH   = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DATAI,
    input  logic             VALIDI,
    output logic             READYI,
    output logic [WIDTH-1:0] DATAO0,
    output logic             VALIDO0,
    input  logic             READYO0,
    output logic [WIDTH-1:0] DATAO1,
    output logic             VALIDO1,
    input  logic             READYO1,
    output logic [7:0]       CNT0,
    output logic [7:0]       CNT1
);
    logic sel;
    logic full0;
    logic full1;
    logic push0;
    logic push1;

    // Ready looks only at the target channel's registered level: a full channel
    // refuses even when it is popping this cycle.
    assign sel    = DATAI[SEL_BIT];
    assign READYI = sel ? ~full0 : ~full1;
    assign push0  = VALIDI & READYI & sel;
    assign push1  = VALIDI & READYI & ~sel;

    data_demux_ch #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ch0 (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push0),
        .din   (DATAI),
        .full  (full0),
        .dout  (DATAO0),
        .valid (VALIDO0),
        .ready (READYO0),
        .cnt   (CNT0)
    );

    data_demux_ch #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ch1 (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push1),
        .din   (DATAI),
        .full  (full1),
        .dout  (DATAO1),
        .valid (VALIDO1),
        .ready (READYO1),
        .cnt   (CNT1)
    );
endmodule
